// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the strip convolution engine.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SAT_PASS = 2'd0,
        SAT_ZERO = 2'd1,
        SAT_MAX  = 2'd2,
        SAT_MIN  = 2'd3
    } sat_sel_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic logic params_ok(input int k, input int img_w, input int img_h,
                                       input int stride, input int data_w, input int coef_w,
                                       input int acc_w, input int rd_lat);
        return (k >= 1) && (img_w >= k) && (img_h >= k) && (stride >= 1) && (rd_lat >= 1) &&
               (acc_w >= data_w + coef_w + clog2(k * k)) && (acc_w <= 64);
    endfunction

    // Decide how a shifted accumulator value maps onto the signed output range.
    function automatic sat_sel_t sat_relu(input logic signed [63:0] v, input logic relu,
                                          input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (relu && (v < 64'sd0)) return SAT_ZERO;
        else if (v > hi)          return SAT_MAX;
        else if (v < lo)          return SAT_MIN;
        else                      return SAT_PASS;
    endfunction

endpackage

// File: rtl/conv_requant.sv
// Registered requantiser: arithmetic right shift, optional ReLU, saturation.
module conv_requant
    import conv_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] acc,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] q
);

    logic signed [ACC_W-1:0] shifted_s;
    sat_sel_t                sel_s;
    logic signed [OUT_W-1:0] q_r;

    // Shift and classify the accumulator against the output range.
    always_comb begin
        shifted_s = acc >>> shift;
        sel_s     = sat_relu(64'(shifted_s), relu_en, OUT_W);
    end

    // Capture the requantised value when the window result is final.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= {OUT_W{1'b0}};
        end else if (en) begin
            case (sel_s)
                SAT_PASS: q_r <= shifted_s[OUT_W-1:0];
                SAT_ZERO: q_r <= {OUT_W{1'b0}};
                SAT_MAX:  q_r <= {1'b0, {(OUT_W-1){1'b1}}};
                SAT_MIN:  q_r <= {1'b1, {(OUT_W-1){1'b0}}};
                default:  q_r <= {OUT_W{1'b0}};
            endcase
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/strip_conv_engine.sv
// KxK strided convolution over one feature-map strip with a single MAC,
// fixed-latency memory reads and a valid/ready result stream.
module strip_conv_engine
    import conv_pkg::*;
#(
    parameter int K      = 3,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 30,
    parameter int STRIDE = 1,
    parameter int DATA_W = 9,
    parameter int COEF_W = 9,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 9,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 16,
    localparam int IDX_W = (clog2(K * K) > 0) ? clog2(K * K) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    input  logic                     coef_we,
    input  logic [IDX_W-1:0]         coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [15:0]              out_row,
    output logic [15:0]              out_col,
    output logic                     busy,
    output logic                     done
);

    localparam int KK = K * K;
    localparam int OH = (IMG_H - K) / STRIDE + 1;
    localparam int OW = (IMG_W - K) / STRIDE + 1;
    localparam int PW = DATA_W + COEF_W;

    if (!params_ok(K, IMG_W, IMG_H, STRIDE, DATA_W, COEF_W, ACC_W, RD_LAT)) begin : g_param_check
        $error("strip_conv_engine: illegal parameter set (check ACC_W, K, STRIDE, RD_LAT)");
    end

    state_t                   state_r;
    logic [ADDR_W-1:0]        base_r;
    logic [4:0]               shift_r;
    logic                     relu_r;
    logic [15:0]              oy_r, ox_r, ky_r, kx_r;
    logic                     rd_en_r;
    logic [ADDR_W-1:0]        rd_addr_r;
    logic                     out_valid_r;
    logic [15:0]              out_row_r, out_col_r;
    logic                     busy_r, done_r;
    logic signed [COEF_W-1:0] kern_r [KK];
    logic [RD_LAT-1:0]        tv_r;
    logic [IDX_W-1:0]         ti_r [RD_LAT];
    logic signed [ACC_W-1:0]  acc_r;
    logic                     acc_last_r;
    logic [IDX_W-1:0]         issue_idx_s;
    logic signed [PW-1:0]     prod_s;

    function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [15:0] oy, input logic [15:0] ox,
                                                   input logic [15:0] ky, input logic [15:0] kx);
        return base + (ADDR_W'(oy) * ADDR_W'(STRIDE) + ADDR_W'(ky)) * ADDR_W'(IMG_W)
                    + ADDR_W'(ox) * ADDR_W'(STRIDE) + ADDR_W'(kx);
    endfunction

    // Kernel index of the read being issued and the full-width MAC product.
    always_comb begin
        issue_idx_s = IDX_W'(int'(ky_r) * K + int'(kx_r));
        prod_s      = PW'(rd_data) * PW'(kern_r[ti_r[RD_LAT-1]]);
    end

    // Kernel registers: writable only while idle so a running strip sees a frozen kernel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < KK; i++) kern_r[i] <= {COEF_W{1'b0}};
        end else if ((state_r == ST_IDLE) && coef_we && (int'(coef_idx) < KK)) begin
            kern_r[coef_idx] <= coef_data;
        end else begin
            kern_r <= kern_r;
        end
    end

    // Read tag pipeline and accumulator; the first product of a window overwrites.
    always_ff @(posedge clk) begin
        if (reset) begin
            tv_r       <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) ti_r[i] <= {IDX_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            acc_last_r <= 1'b0;
        end else begin
            tv_r[0] <= rd_en_r;
            ti_r[0] <= issue_idx_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tv_r[i] <= tv_r[i-1];
                ti_r[i] <= ti_r[i-1];
            end
            if (tv_r[RD_LAT-1]) begin
                acc_r      <= (ti_r[RD_LAT-1] == {IDX_W{1'b0}}) ? ACC_W'(prod_s)
                                                                 : acc_r + ACC_W'(prod_s);
                acc_last_r <= (int'(ti_r[RD_LAT-1]) == KK - 1);
            end else begin
                acc_r      <= ((state_r == ST_IDLE) && start) ? {ACC_W{1'b0}} : acc_r;
                acc_last_r <= 1'b0;
            end
        end
    end

    // Control FSM: window walk, read issue, output handshake and completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            base_r      <= {ADDR_W{1'b0}};
            shift_r     <= 5'd0;
            relu_r      <= 1'b0;
            oy_r        <= 16'd0;
            ox_r        <= 16'd0;
            ky_r        <= 16'd0;
            kx_r        <= 16'd0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
            out_row_r   <= 16'd0;
            out_col_r   <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r    <= base_addr;
                        shift_r   <= shift;
                        relu_r    <= relu_en;
                        oy_r      <= 16'd0;
                        ox_r      <= 16'd0;
                        ky_r      <= 16'd0;
                        kx_r      <= 16'd0;
                        busy_r    <= 1'b1;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= win_addr(base_addr, 16'd0, 16'd0, 16'd0, 16'd0);
                        state_r   <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if ((ky_r == 16'(K - 1)) && (kx_r == 16'(K - 1))) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_WAIT;
                    end else if (kx_r == 16'(K - 1)) begin
                        kx_r      <= 16'd0;
                        ky_r      <= ky_r + 16'd1;
                        rd_addr_r <= win_addr(base_r, oy_r, ox_r, ky_r + 16'd1, 16'd0);
                    end else begin
                        kx_r      <= kx_r + 16'd1;
                        rd_addr_r <= win_addr(base_r, oy_r, ox_r, ky_r, kx_r + 16'd1);
                    end
                end
                ST_WAIT: begin
                    if (acc_last_r) begin
                        out_valid_r <= 1'b1;
                        out_row_r   <= oy_r;
                        out_col_r   <= ox_r;
                        state_r     <= ST_EMIT;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        ky_r        <= 16'd0;
                        kx_r        <= 16'd0;
                        if ((oy_r == 16'(OH - 1)) && (ox_r == 16'(OW - 1))) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else if (ox_r == 16'(OW - 1)) begin
                            ox_r      <= 16'd0;
                            oy_r      <= oy_r + 16'd1;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= win_addr(base_r, oy_r + 16'd1, 16'd0, 16'd0, 16'd0);
                            state_r   <= ST_FETCH;
                        end else begin
                            ox_r      <= ox_r + 16'd1;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= win_addr(base_r, oy_r, ox_r + 16'd1, 16'd0, 16'd0);
                            state_r   <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    conv_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .clk     (clk),
        .reset   (reset),
        .en      (acc_last_r),
        .acc     (acc_r),
        .shift   (shift_r),
        .relu_en (relu_r),
        .q       (out_data)
    );

    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign out_valid = out_valid_r;
    assign out_row   = out_row_r;
    assign out_col   = out_col_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_strip_conv_engine.sv
// Scoreboard bench for strip_conv_engine on a small strided strip (K=3, 8x6, STRIDE=2).
module tb_strip_conv_engine;

    localparam int K = 3, IMG_W = 8, IMG_H = 6, STRIDE = 2, RD_LAT = 2;
    localparam int OH = (IMG_H - K) / STRIDE + 1;
    localparam int OW = (IMG_W - K) / STRIDE + 1;

    logic clk = 1'b0;
    logic reset, start, relu_en, coef_we;
    logic out_ready = 1'b1;
    logic [15:0] base_addr;
    logic [4:0] shift;
    logic [3:0] coef_idx;
    logic signed [8:0] coef_data, rd_data, out_data;
    logic rd_en, out_valid, busy, done;
    logic [15:0] rd_addr, out_row, out_col;

    always #5 clk = ~clk;

    strip_conv_engine #(
        .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .STRIDE(STRIDE), .DATA_W(9), .COEF_W(9),
        .ACC_W(32), .OUT_W(9), .RD_LAT(RD_LAT), .ADDR_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .shift(shift),
        .relu_en(relu_en), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    int total = 0, bad = 0, cyc = 0;
    int pix_mode = 0, pix_const = 1;
    int exp_d[$], exp_r[$], exp_c[$], exp_a[$];
    int hs_cnt = 0, done_cnt = 0, t_first = 0, low_run = 0;
    int h_d, h_r, h_c;
    bit held_f = 1'b0, prev_rd = 1'b0, prev_ov = 1'b0, stall_en = 1'b0;

    typedef struct {int pix; int coef; int sh; int rl; int exp;} vec_t;
    vec_t vecs[10] = '{
        '{1, 1, 0, 0, 9},        '{1, 1, 1, 0, 4},        '{1, -1, 1, 0, -5},
        '{127, 127, 0, 0, 255},  '{127, -127, 0, 0, -256}, '{127, -127, 0, 1, 0},
        '{127, 127, 8, 0, 255},  '{-3, 5, 0, 0, -135},    '{-3, 5, 0, 1, 0},
        '{2, -7, 0, 0, -126}
    };

    function automatic int pix(input int a);
        if (pix_mode == 1) return (a % 100) - 50;
        else return pix_const;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strip memory model with RD_LAT=2 registered read.
    logic signed [8:0] p1 = 9'sd0, p2 = 9'sd0;
    always @(posedge clk) begin
        p1 <= rd_en ? 9'(pix(int'(rd_addr))) : 9'sd0;
        p2 <= p1;
    end
    assign rd_data = p2;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (stall_en && low_run < 10 && $urandom_range(0, 2) == 0) begin
            out_ready = 1'b0;
            low_run++;
        end else begin
            out_ready = 1'b1;
            low_run = 0;
        end
    end

    // Monitor: address scoreboard, output scoreboard, stall stability, latency, done count.
    always @(negedge clk) begin
        if (reset) begin
            held_f = 1'b0; prev_rd = 1'b0; prev_ov = 1'b0;
        end else begin
            if (rd_en) begin
                if (!prev_rd) t_first = cyc;
                if (exp_a.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", int'(rd_addr), exp_a.pop_front());
            end
            if (out_valid) begin
                if (!prev_ov) check("latency", cyc - t_first, K * K + RD_LAT + 1);
                check("rd_en_in_emit", int'(rd_en), 0);
                if (held_f) begin
                    check("stall_data", int'(out_data), h_d);
                    check("stall_row", int'(out_row), h_r);
                    check("stall_col", int'(out_col), h_c);
                end
                h_d = int'(out_data); h_r = int'(out_row); h_c = int'(out_col);
                held_f = !out_ready;
                if (out_ready) begin
                    hs_cnt++;
                    if (exp_d.size() == 0) check("out_unexpected", 1, 0);
                    else begin
                        check("out_data", int'(out_data), exp_d.pop_front());
                        check("out_row", int'(out_row), exp_r.pop_front());
                        check("out_col", int'(out_col), exp_c.pop_front());
                    end
                end
            end else begin
                held_f = 1'b0;
            end
            if (done) done_cnt++;
            prev_rd = rd_en; prev_ov = out_valid;
        end
    end

    task automatic write_coef(input int idx, input int val);
        coef_we = 1'b1; coef_idx = 4'(idx); coef_data = 9'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic push_expect(input int base, input bit centre, input int uni);
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        exp_a.push_back((base + (oy * STRIDE + ky) * IMG_W + ox * STRIDE + kx) & 16'hffff);
                exp_r.push_back(oy);
                exp_c.push_back(ox);
                exp_d.push_back(centre ? pix((base + (oy * STRIDE + 1) * IMG_W + ox * STRIDE + 1) & 16'hffff) : uni);
            end
    endtask

    task automatic run_strip(input int base, input int sh, input int rl, input bit poke, input bit co_we);
        int d0;
        bit seen;
        d0 = done_cnt; seen = 1'b0;
        start = 1'b1; base_addr = 16'(base); shift = 5'(sh); relu_en = rl[0];
        if (co_we) begin coef_we = 1'b1; coef_idx = 4'd8; coef_data = 9'sd1; end
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0;
        check("busy_after_start", int'(busy), 1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            write_coef(4, -100);
        end
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after_done", int'(busy), 0);
        check("out_left", exp_d.size(), 0);
        check("addr_left", exp_a.size(), 0);
    endtask

    initial begin
        int h0;
        bit hit;
        reset = 1'b1; start = 1'b0; coef_we = 1'b0; relu_en = 1'b0;
        base_addr = 16'd0; shift = 5'd0; coef_idx = 4'd0; coef_data = 9'sd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_row_col", int'(out_row) + int'(out_col), 0);
        check("rst_busy_done", int'(busy) + int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Uniform pixels/kernels: sums, arithmetic shift, ReLU and saturation.
        pix_mode = 0;
        foreach (vecs[v]) begin
            pix_const = vecs[v].pix;
            for (int i = 0; i < K * K; i++) write_coef(i, vecs[v].coef);
            push_expect((v == 9) ? 16'hfff0 : 40 + v * 3, 1'b0, vecs[v].exp);
            run_strip((v == 9) ? 16'hfff0 : 40 + v * 3, vecs[v].sh, vecs[v].rl, 1'b0, 1'b0);
        end

        // Centre-only kernel passes the window-centre pixel through.
        pix_mode = 1;
        for (int i = 0; i < K * K; i++) write_coef(i, (i == 4) ? 1 : 0);
        push_expect(100, 1'b1, 0);
        run_strip(100, 0, 0, 1'b0, 1'b0);

        // Same run under backpressure, with a kernel write attempted mid-strip.
        stall_en = 1'b1;
        push_expect(100, 1'b1, 0);
        run_strip(100, 0, 0, 1'b1, 1'b0);
        stall_en = 1'b0;
        @(posedge clk); #1;

        // Reset during FETCH of the fifth window aborts without a done pulse.
        pix_mode = 0; pix_const = 1;
        for (int i = 0; i < K * K; i++) write_coef(i, 1);
        push_expect(0, 1'b0, 9);
        h0 = hs_cnt; hit = 1'b0;
        start = 1'b1; base_addr = 16'd0; shift = 5'd0; relu_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge clk); #1;
            if (hs_cnt >= h0 + 4 && rd_en) hit = 1'b1;
        end
        if (!hit) check("fetch5_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("fetch5_rd_en", int'(rd_en), 1);
        h0 = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_rd_en", int'(rd_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        reset = 1'b0;
        exp_d.delete(); exp_r.delete(); exp_c.delete(); exp_a.delete();
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - h0, 0);

        // Kernel was cleared; last coefficient written in the same cycle as start.
        for (int i = 0; i < K * K - 1; i++) write_coef(i, 1);
        push_expect(0, 1'b0, 9);
        run_strip(0, 0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
